// File: rtl/divu_hilo_unit_if.sv
// Pipeline-side signal bundle for the unsigned divide / HI-LO unit.
// The master drives EX-stage op code and operands; the slave returns HI/LO data and status.
interface divu_hilo_unit_if #(
    parameter int WIDTH = 32
);
    logic [5:0]       ALUOperation;
    logic             op_valid;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] hilo_out;
    logic             busy;
    logic             done;

    modport master (
        output ALUOperation, op_valid, dividend, divisor,
        input  hilo_out, busy, done
    );

    modport slave (
        input  ALUOperation, op_valid, dividend, divisor,
        output hilo_out, busy, done
    );
endinterface

// File: rtl/divu_hilo_unit.sv
// Multi-cycle restoring unsigned divider with HI (remainder) / LO (quotient) registers.
// One quotient bit per cycle; mfhi/mflo read HI/LO combinationally.
module divu_hilo_unit #(
    parameter int         WIDTH  = 32,
    parameter logic [5:0] F_DIVU = 6'd27,
    parameter logic [5:0] F_MFHI = 6'd16,
    parameter logic [5:0] F_MFLO = 6'd18
) (
    input  logic            clk,
    input  logic            rst,
    divu_hilo_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [5:0]       r_count;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_start;
    logic [WIDTH:0]   w_shRem;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_nextRem;
    logic [WIDTH-1:0] w_nextQuo;
    logic [WIDTH-1:0] w_hiloOut;

    assign w_start = bus.op_valid && (bus.ALUOperation == F_DIVU) && (r_state != DIV);

    // One restoring step: when the shifted remainder fits, the true difference is
    // below the divisor, so a WIDTH-bit subtraction is exact.
    assign w_shRem   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shRem >= {1'b0, r_dvs});
    assign w_diff    = w_shRem[WIDTH-1:0] - r_dvs;
    assign w_nextRem = w_ge ? w_diff : w_shRem[WIDTH-1:0];
    assign w_nextQuo = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start) begin
                        r_quo   <= bus.dividend;
                        r_rem   <= '0;
                        r_dvs   <= bus.divisor;
                        r_count <= '0;
                        r_state <= DIV;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DIV: begin
                    r_rem   <= w_nextRem;
                    r_quo   <= w_nextQuo;
                    r_count <= r_count + 6'd1;
                    if (r_count == LAST_STEP) begin
                        r_hi    <= w_nextRem;
                        r_lo    <= w_nextQuo;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // HI/LO reads see the committed registers only, so a read during DIV returns old data.
    always_comb begin
        w_hiloOut = '0;
        if (bus.op_valid && (bus.ALUOperation == F_MFHI)) begin
            w_hiloOut = r_hi;
        end else if (bus.op_valid && (bus.ALUOperation == F_MFLO)) begin
            w_hiloOut = r_lo;
        end
    end

    assign bus.hilo_out = w_hiloOut;
    assign bus.busy     = (r_state == DIV);
    assign bus.done     = (r_state == DONE);

endmodule

// File: doc/divu_hilo_unit.md
DIVU_HILO_UNIT -- requirements
Module: divu_hilo_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width.
REQ-002 Parameter: F_DIVU, 6'd27, op code for unsigned divide.
REQ-003 Parameter: F_MFHI, 6'd16, op code for read HI.
REQ-004 Parameter: F_MFLO, 6'd18, op code for read LO.
REQ-005 Port: clk  input  1  single clock, all state on rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-high reset.
REQ-007 Port: ALUOperation  input  6  op code from ALU control (EX stage).
REQ-008 Port: op_valid  input  1  EX-stage instruction valid (not bubble/flushed).
REQ-009 Port: dividend  input  WIDTH  rs operand.
REQ-010 Port: divisor  input  WIDTH  rt operand.
REQ-011 Port: hilo_out  output  WIDTH  HI/LO read data for mfhi/mflo.
REQ-012 Port: busy  output  1  divide in progress; hazard unit stalls HI/LO users and younger divu.
REQ-013 Port: done  output  1  one-cycle pulse, HI/LO just updated.

Function
REQ-014 State machine SHALL have three states: IDLE, DIV, DONE.
REQ-015 start = op_valid && ALUOperation==F_DIVU && state!=DIV; only then SHALL operands be latched.
REQ-016 On start edge: quotient reg <= dividend, remainder reg <= 0, divisor reg <= divisor, count <= 0, state <= DIV.
REQ-017 In DIV, each cycle SHALL do one restoring step: shift {rem,quo} left 1; if shifted rem (WIDTH+1 bits) >= divisor reg, subtract and set quo LSB=1, else LSB=0.
REQ-018 count (6 bits) SHALL increment per DIV cycle; on the edge completing step 31, HI <= remainder, LO <= quotient, state <= DONE.
REQ-019 Latency: start accepted at edge E0 -> HI/LO updated at edge E32 -> done=1 during cycle after E32.
REQ-020 DONE SHALL last exactly one cycle -> IDLE, or -> DIV if start true in that cycle.
REQ-021 busy SHALL equal (state==DIV), registered-state decode only; done SHALL equal (state==DONE).
REQ-022 ALUOperation==F_DIVU with op_valid while state==DIV SHALL be ignored (no relatch, no restart).
REQ-023 Divisor zero: iteration still runs 32 cycles; result SHALL be HI=dividend, LO=all ones (natural restoring result, no special case).
REQ-024 hilo_out SHALL be combinational: op_valid && op==F_MFHI -> HI; op_valid && op==F_MFLO -> LO; else 0.
REQ-025 mfhi/mflo while busy SHALL return old HI/LO (stall is hazard unit's job); in DONE cycle SHALL return new values.
REQ-026 Any other op code SHALL leave all state unchanged.
REQ-027 Arithmetic SHALL be unsigned throughout; no overflow/exception output.

Reset
REQ-028 rst high SHALL immediately force state=IDLE, HI=0, LO=0, count=0, internal regs=0, busy=0, done=0.
REQ-029 rst asserted mid-DIV SHALL abort the divide; HI/LO SHALL read 0 afterward, no done pulse.
REQ-030 After rst deasserts, first rising edge with start SHALL begin a new divide normally.

Verification
REQ-031 divu 100/7 -> busy=1 for 32 cycles, done pulse in cycle 33, then mfhi=2, mflo=14.
REQ-032 divu 0xFFFFFFFF/1 -> HI=0, LO=0xFFFFFFFF; divu 5/0 -> HI=5, LO=0xFFFFFFFF.
REQ-033 mfhi issued at cycle 10 of divide (HI previously 3) -> hilo_out=3, busy=1; mfhi in DONE cycle -> new HI.
REQ-034 second divu 9/4 presented during DIV -> ignored; presented during DONE of 100/7 -> accepted, HI=1, LO=2 after 33 more cycles.
REQ-035 rst pulse at cycle 15 of divide -> busy=0 immediately, no done, mfhi/mflo return 0.
REQ-036 op_valid=0 with ALUOperation=F_DIVU -> no start; mflo with op_valid=0 -> hilo_out=0.
